// File: rtl/vehicle_pkg.sv
// Shared gear codes, reject causes and the gear-state type for the lever front end.
package vehicle_pkg;

  localparam logic [3:0] GEAR_P = 4'd3;
  localparam logic [3:0] GEAR_R = 4'd6;
  localparam logic [3:0] GEAR_N = 4'd9;
  localparam logic [3:0] GEAR_D = 4'd12;

  localparam logic [1:0] REJ_NONE   = 2'd0;
  localparam logic [1:0] REJ_BRAKE  = 2'd1;
  localparam logic [1:0] REJ_SPEED  = 2'd2;
  localparam logic [1:0] REJ_ENGINE = 2'd3;

  // State encoding is the dashboard gear code itself, so no output decode is needed.
  typedef enum logic [3:0] {
    ST_P = GEAR_P,
    ST_R = GEAR_R,
    ST_N = GEAR_N,
    ST_D = GEAR_D
  } gear_e;

endpackage

// File: rtl/button_debounce.sv
// Tick-sampled debouncer: accepts a new level after DEBOUNCE_TICKS steady ticks and
// emits a one-clk press pulse on each accepted 0->1 transition.
module button_debounce #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (raw == level_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        cnt_d   = '0;
        level_d = raw;
        press_d = raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/gear_selector.sv
// Lever front end: debounced buttons drive the P/R/N/D FSM with brake/speed/engine interlocks.
// Optional AUTO_PARK_EN: engine-off at standstill forces P on the next clock.
module gear_selector
  import vehicle_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int P_SPEED_MAX    = 3,
  parameter int R_SPEED_MAX    = 5,
  parameter int LIMIT_INIT     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       engine_on,
  input  logic [7:0] speed,
  input  logic       is_brake_normal,
  input  logic       sw_low_gear,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_lim_up_raw,
  input  logic       btn_lim_down_raw,
  output logic [3:0] current_gear,
  output logic       is_low_gear_mode,
  output logic [2:0] max_gear_limit,
  output logic       shift_reject,
  output logic [1:0] reject_code
);

  logic up_p, down_p, lim_up_p, lim_down_p;

  button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_up (
    .clk(clk), .rst(rst), .tick(tick_1ms), .raw(btn_up_raw), .level(), .press(up_p));
  button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_down (
    .clk(clk), .rst(rst), .tick(tick_1ms), .raw(btn_down_raw), .level(), .press(down_p));
  button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_lim_up (
    .clk(clk), .rst(rst), .tick(tick_1ms), .raw(btn_lim_up_raw), .level(), .press(lim_up_p));
  button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_lim_down (
    .clk(clk), .rst(rst), .tick(tick_1ms), .raw(btn_lim_down_raw), .level(), .press(lim_down_p));

  gear_e      gear_q, gear_d, target;
  logic       low_q, low_d;
  logic [2:0] limit_q, limit_d;
  logic       rej_q, rej_d;
  logic [1:0] code_q, code_d, cause;
  logic       step_up, step_dn, p_speed_ok, r_speed_ok;

`ifdef AUTO_PARK_EN
  logic engine_q;
  logic park;
  assign park = engine_q && !engine_on && (speed == 8'd0);
`endif

  assign step_up    = up_p && !down_p;
  assign step_dn    = down_p && !up_p;
  assign p_speed_ok = speed <= 8'(P_SPEED_MAX);
  assign r_speed_ok = speed <= 8'(R_SPEED_MAX);

  always_comb begin
    gear_d  = gear_q;
    rej_d   = 1'b0;
    code_d  = code_q;
    limit_d = limit_q;
    target  = gear_q;
    cause   = REJ_NONE;

    unique case (gear_q)
      ST_P:    target = step_dn ? ST_R : ST_P;
      ST_R:    target = step_up ? ST_P : (step_dn ? ST_N : ST_R);
      ST_N:    target = step_up ? ST_R : (step_dn ? ST_D : ST_N);
      ST_D:    target = step_up ? ST_N : ST_D;
      default: target = ST_P;
    endcase

    // Guards in priority order; only R->P at low speed survives engine-off.
    if (!engine_on && !(gear_q == ST_R && target == ST_P && p_speed_ok)) cause = REJ_ENGINE;
    else if (gear_q == ST_P && !is_brake_normal)                         cause = REJ_BRAKE;
    else if (target == ST_P && !p_speed_ok)                              cause = REJ_SPEED;
    else if (gear_q == ST_N && target == ST_R && !r_speed_ok)            cause = REJ_SPEED;

    if (target != gear_q) begin
      if (cause == REJ_NONE) begin
        gear_d = target;
      end else begin
        rej_d  = 1'b1;
        code_d = cause;
      end
    end

`ifdef AUTO_PARK_EN
    if (park) begin
      gear_d = ST_P;
      rej_d  = 1'b0;
      code_d = code_q;
    end
`endif

    low_d = sw_low_gear && (gear_q == ST_D);
    if (low_d) begin
      if (lim_up_p && !lim_down_p && limit_q < 3'd6)      limit_d = limit_q + 3'd1;
      else if (lim_down_p && !lim_up_p && limit_q > 3'd1) limit_d = limit_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gear_q  <= ST_P;
      low_q   <= 1'b0;
      limit_q <= 3'(LIMIT_INIT);
      rej_q   <= 1'b0;
      code_q  <= REJ_NONE;
    end else begin
      gear_q  <= gear_d;
      low_q   <= low_d;
      limit_q <= limit_d;
      rej_q   <= rej_d;
      code_q  <= code_d;
    end
  end

`ifdef AUTO_PARK_EN
  always_ff @(posedge clk) begin
    if (rst) engine_q <= 1'b0;
    else     engine_q <= engine_on;
  end
`endif

  assign current_gear     = gear_q;
  assign is_low_gear_mode = low_q;
  assign max_gear_limit   = limit_q;
  assign shift_reject     = rej_q;
  assign reject_code      = code_q;

endmodule

// File: tb/tb_gear_selector.sv
// Self-checking bench for gear_selector: lever-rule model compared every cycle plus
// directed literal expectations for each scenario.
module tb_gear_selector;

  localparam int DT       = 20;
  localparam int PMAX     = 3;
  localparam int RMAX     = 5;
  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1ms = 1'b0;
  logic       engine_on = 1'b0;
  logic [7:0] speed = 8'd0;
  logic       is_brake_normal = 1'b0;
  logic       sw_low_gear = 1'b0;
  logic       btn_up_raw = 1'b0;
  logic       btn_down_raw = 1'b0;
  logic       btn_lim_up_raw = 1'b0;
  logic       btn_lim_down_raw = 1'b0;
  logic [3:0] current_gear;
  logic       is_low_gear_mode;
  logic [2:0] max_gear_limit;
  logic       shift_reject;
  logic [1:0] reject_code;

  int errors = 0;
  int checks = 0;
  int rej_seen = 0;

  gear_selector #(
    .DEBOUNCE_TICKS(DT), .P_SPEED_MAX(PMAX), .R_SPEED_MAX(RMAX), .LIMIT_INIT(2)
  ) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .engine_on(engine_on), .speed(speed),
    .is_brake_normal(is_brake_normal), .sw_low_gear(sw_low_gear),
    .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
    .btn_lim_up_raw(btn_lim_up_raw), .btn_lim_down_raw(btn_lim_down_raw),
    .current_gear(current_gear), .is_low_gear_mode(is_low_gear_mode),
    .max_gear_limit(max_gear_limit), .shift_reject(shift_reject), .reject_code(reject_code)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      tick_1ms = 1'b1;
      @(negedge clk);
      tick_1ms = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: lever position as index 0..3 (P,R,N,D); code = 3*(index+1).
  int  m_idx = 0, m_lim = 2, m_code = 0;
  bit  m_low = 0, m_rej = 0, started = 0, eng_prev = 0;
  bit  acc[4], last_raw[4], pend[4], raw_now[4];
  int  same[4];

  function automatic int code_of(input int idx);
    return 3 * (idx + 1);
  endfunction

  initial begin
    int  tgt, cause;
    bit  park;
    forever begin
      @(posedge clk);
      raw_now = '{btn_up_raw, btn_down_raw, btn_lim_up_raw, btn_lim_down_raw};
      if (rst) begin
        m_idx = 0; m_lim = 2; m_code = 0; m_low = 0; m_rej = 0; eng_prev = 0;
        for (int b = 0; b < 4; b++) begin
          acc[b] = 0; pend[b] = 0; same[b] = 0; last_raw[b] = raw_now[b];
        end
      end else begin
        m_low = sw_low_gear && (m_idx == 3);
        m_rej = 0;
        if (m_low && pend[2] && !pend[3]) m_lim = (m_lim < 6) ? m_lim + 1 : 6;
        if (m_low && pend[3] && !pend[2]) m_lim = (m_lim > 1) ? m_lim - 1 : 1;
        park = 0;
`ifdef AUTO_PARK_EN
        park = eng_prev && !engine_on && (speed == 0);
`endif
        if (park) begin
          m_idx = 0;
        end else begin
          tgt = m_idx;
          if (pend[0] && !pend[1] && m_idx > 0) tgt = m_idx - 1;
          if (pend[1] && !pend[0] && m_idx < 3) tgt = m_idx + 1;
          if (tgt != m_idx) begin
            cause = 0;
            if (!engine_on && !(m_idx == 1 && tgt == 0 && speed <= PMAX)) cause = 3;
            else if (m_idx == 0 && !is_brake_normal)                     cause = 1;
            else if (tgt == 0 && speed > PMAX)                           cause = 2;
            else if (m_idx == 2 && tgt == 1 && speed > RMAX)             cause = 2;
            if (cause == 0) m_idx = tgt;
            else begin m_rej = 1; m_code = cause; end
          end
        end
        eng_prev = engine_on;
        // A level is accepted once raw has been unchanged for DT ticks and differs from it.
        for (int b = 0; b < 4; b++) begin
          pend[b] = 0;
          if (raw_now[b] != last_raw[b]) begin
            last_raw[b] = raw_now[b];
            same[b] = 0;
          end
          if (tick_1ms) begin
            same[b]++;
            if (same[b] == DT && raw_now[b] != acc[b]) begin
              acc[b]  = raw_now[b];
              pend[b] = raw_now[b];
            end
          end
        end
      end
      started = 1;
    end
  end

  initial begin
    logic [10:0] act_v, exp_v;
    forever begin
      @(negedge clk);
      if (started) begin
        if (shift_reject === 1'b1) rej_seen++;
        act_v = {current_gear, is_low_gear_mode, max_gear_limit, shift_reject, reject_code};
        exp_v = {4'(code_of(m_idx)), m_low, 3'(m_lim), m_rej, 2'(m_code)};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL cycle_model @%0t: got %h expected %h", $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic wait_ms(input int n);
    repeat (n * TICK_DIV) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_up_raw = v;
      1:       btn_down_raw = v;
      2:       btn_lim_up_raw = v;
      default: btn_lim_down_raw = v;
    endcase
  endtask

  task automatic tap(input int b);
    set_btn(b, 1'b1);
    wait_ms(25);
    set_btn(b, 1'b0);
    wait_ms(25);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r0;
    do_reset();
    check("rst_gear", current_gear, 3);
    check("rst_limit", max_gear_limit, 2);
    check("rst_code", reject_code, 0);
    check("rst_low", is_low_gear_mode, 0);
    check("rst_reject", shift_reject, 0);

    // Leaving P without brake
    engine_on = 1'b1; speed = 8'd0; is_brake_normal = 1'b0;
    r0 = rej_seen;
    set_btn(1, 1'b1); wait_ms(25);
    check("nobrake_gear", current_gear, 3);
    check("nobrake_pulses", rej_seen - r0, 1);
    check("nobrake_code", reject_code, 1);
    set_btn(1, 1'b0); wait_ms(25);

    // Brake pressed: step down through the lever; long hold is a single step
    is_brake_normal = 1'b1;
    r0 = rej_seen;
    tap(1); check("down_to_R", current_gear, 6);
    tap(1); check("down_to_N", current_gear, 9);
    set_btn(1, 1'b1); wait_ms(60); set_btn(1, 1'b0); wait_ms(25);
    check("hold_to_D", current_gear, 12);
    tap(1); check("down_in_D", current_gear, 12);
    btn_up_raw = 1'b1; btn_down_raw = 1'b1; wait_ms(25);
    btn_up_raw = 1'b0; btn_down_raw = 1'b0; wait_ms(25);
    check("both_ignored", current_gear, 12);
    check("no_rej_noops", rej_seen - r0, 0);

    // Speed gating
    speed = 8'd40;
    tap(0); check("D_to_N_fast", current_gear, 9);
    r0 = rej_seen;
    tap(0); check("N_to_R_fast", current_gear, 9);
    check("N_to_R_code", reject_code, 2);
    check("N_to_R_pulse", rej_seen - r0, 1);
    speed = 8'd5;
    tap(0); check("N_to_R_5kmh", current_gear, 6);
    tap(0); check("R_to_P_5kmh", current_gear, 6);
    speed = 8'd3;
    tap(0); check("R_to_P_3kmh", current_gear, 3);

    // Bouncing up button: 5-tick chatter for 100 ms, then a clean hold
    speed = 8'd0;
    tap(1); tap(1);
    check("bounce_start_N", current_gear, 9);
    for (int i = 0; i < 20; i++) begin
      btn_up_raw = ~btn_up_raw;
      wait_ms(5);
    end
    check("bounce_no_step", current_gear, 9);
    btn_up_raw = 1'b1; wait_ms(25);
    check("bounce_one_step", current_gear, 6);
    btn_up_raw = 1'b0; wait_ms(25);
    check("bounce_settled", current_gear, 6);

    // Gear limit in low-gear mode
    tap(1); tap(1);
    sw_low_gear = 1'b1; wait_ms(1);
    check("low_mode_D", is_low_gear_mode, 1);
    for (int i = 0; i < 3; i++) tap(3);
    check("lim_floor", max_gear_limit, 1);
    for (int i = 0; i < 7; i++) tap(2);
    check("lim_ceiling", max_gear_limit, 6);
    tap(3); check("lim_dec", max_gear_limit, 5);
    tap(0);
    check("low_N_gear", current_gear, 9);
    check("low_mode_N", is_low_gear_mode, 0);
    tap(2); check("lim_up_ignored", max_gear_limit, 5);
    tap(3); check("lim_dn_ignored", max_gear_limit, 5);
    tap(1); check("low_mode_back", is_low_gear_mode, 1);
    sw_low_gear = 1'b0; wait_ms(1);
    check("low_mode_off", is_low_gear_mode, 0);

    // Engine off at standstill in D
    engine_on = 1'b0; wait_ms(2);
    r0 = rej_seen;
`ifdef AUTO_PARK_EN
    check("autopark_gear", current_gear, 3);
    tap(0); check("autopark_up_noop", rej_seen - r0, 0);
`else
    check("engoff_hold_D", current_gear, 12);
    tap(0);
    check("engoff_up_gear", current_gear, 12);
    check("engoff_up_code", reject_code, 3);
    check("engoff_up_pulse", rej_seen - r0, 1);
`endif

    // R->P allowed with engine off at low speed; P->R refused
    do_reset();
    engine_on = 1'b1; is_brake_normal = 1'b1; speed = 8'd2;
    tap(1); check("pre_R", current_gear, 6);
    engine_on = 1'b0; wait_ms(2);
    tap(0); check("engoff_R_to_P", current_gear, 3);
    tap(1); check("engoff_P_to_R", current_gear, 3);
    check("engoff_P_to_R_code", reject_code, 3);

    // Reset in the middle of a debounce aborts it
    engine_on = 1'b1; speed = 8'd0;
    do_reset();
    r0 = rej_seen;
    set_btn(1, 1'b1); wait_ms(15);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    wait_ms(10); set_btn(1, 1'b0); wait_ms(25);
    check("rst_abort_gear", current_gear, 3);
    check("rst_abort_pulse", rej_seen - r0, 0);
    check("rst_abort_code", reject_code, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
